// File: rtl/cache_controller_if.sv
// ---------------------------------------------------------------------------
// cache_controller_if : CPU, cache and main-memory buses of the cache controller
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface cache_controller_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_done;
  logic              cpu_busy;

  logic [ADDR_W-1:0] cache_addr;
  logic [DATA_W-1:0] cache_wdata;
  logic              cache_we;
  logic [DATA_W-1:0] cache_rdata;
  logic              cache_hit;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // controller side: owns every cache and memory strobe
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done, cpu_busy,
    output cache_addr, cache_wdata, cache_we,
    input  cache_rdata, cache_hit,
    output mem_addr, mem_wdata, mem_rd_en, mem_wr_en,
    input  mem_rdata, mem_ack
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done, cpu_busy,
    input  cache_addr, cache_wdata, cache_we,
    output cache_rdata, cache_hit,
    input  mem_addr, mem_wdata, mem_rd_en, mem_wr_en,
    output mem_rdata, mem_ack
  );
endinterface

`default_nettype wire

// File: rtl/cache_controller.sv
// ---------------------------------------------------------------------------
// cache_controller : direct-mapped write-through cache sequencer, read-miss line
//   fill, no write allocate. Optional macro CACHE_PERF_COUNT_EN adds hit/miss counts.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cache_controller #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int OFF_W  = 2
) (
  input  wire logic clk_100,
  input  wire logic rst_n,
`ifdef CACHE_PERF_COUNT_EN
  output logic [15:0] hit_count,
  output logic [15:0] miss_count,
`endif
  cache_controller_if.master bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_CHECK     = 3'd2;
  localparam logic [2:0] S_FILL      = 3'd3;
  localparam logic [2:0] S_FILL_WR   = 3'd4;
  localparam logic [2:0] S_WRITE_MEM = 3'd5;
  localparam logic [2:0] S_RESP      = 3'd6;

  localparam logic [OFF_W-1:0] FILL_LAST = {OFF_W{1'b1}};

  logic [2:0]        state;
  logic [2:0]        next_state;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [OFF_W-1:0]  fill_cnt;
  logic [DATA_W-1:0] fill_data;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] fill_addr;

  // line fills always walk the whole line from offset 0
  assign fill_addr = {req_addr[ADDR_W-1:OFF_W], fill_cnt};

  always_ff @(posedge clk_100) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (bus.cpu_req) next_state = S_LOOKUP;
      S_LOOKUP:    next_state = S_CHECK;
      S_CHECK: begin
        if (req_we)             next_state = S_WRITE_MEM;
        else if (bus.cache_hit) next_state = S_RESP;
        else                    next_state = S_FILL;
      end
      S_FILL:      if (bus.mem_ack) next_state = S_FILL_WR;
      S_FILL_WR:   next_state = (fill_cnt == FILL_LAST) ? S_LOOKUP : S_FILL;
      S_WRITE_MEM: if (bus.mem_ack) next_state = S_RESP;
      S_RESP:      next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      fill_cnt  <= '0;
      fill_data <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cpu_req) begin
            req_we    <= bus.cpu_we;
            req_addr  <= bus.cpu_addr;
            req_wdata <= bus.cpu_wdata;
          end
        end
        S_CHECK: begin
          if (!req_we) begin
            if (bus.cache_hit) rdata_q  <= bus.cache_rdata;
            else               fill_cnt <= '0;
          end
        end
        S_FILL:    if (bus.mem_ack) fill_data <= bus.mem_rdata;
        S_FILL_WR: if (fill_cnt != FILL_LAST) fill_cnt <= fill_cnt + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CACHE_PERF_COUNT_EN
  // marks the CHECK that follows a completed fill so it is not counted
  logic relookup;

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      relookup   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state == S_FILL_WR && fill_cnt == FILL_LAST) relookup <= 1'b1;
      if (state == S_CHECK) begin
        relookup <= 1'b0;
        if (!relookup) begin
          if (bus.cache_hit) begin
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
          end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
          end
        end
      end
    end
  end
`endif

  always_comb begin
    bus.cpu_rdata   = rdata_q;
    bus.cpu_done    = 1'b0;
    bus.cpu_busy    = (state != S_IDLE);
    bus.cache_addr  = '0;
    bus.cache_wdata = '0;
    bus.cache_we    = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_wr_en   = 1'b0;
    case (state)
      S_LOOKUP: bus.cache_addr = req_addr;
      S_CHECK: begin
        bus.cache_addr = req_addr;
        if (req_we && bus.cache_hit) begin
          bus.cache_we    = 1'b1;
          bus.cache_wdata = req_wdata;
        end
      end
      S_FILL: begin
        bus.mem_addr  = fill_addr;
        bus.mem_rd_en = 1'b1;
      end
      S_FILL_WR: begin
        bus.cache_addr  = fill_addr;
        bus.cache_wdata = fill_data;
        bus.cache_we    = 1'b1;
      end
      S_WRITE_MEM: begin
        bus.mem_addr  = req_addr;
        bus.mem_wdata = req_wdata;
        bus.mem_wr_en = 1'b1;
      end
      S_RESP:  bus.cpu_done = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_controller.sv
// ---------------------------------------------------------------------------
// tb_cache_controller : directed self-checking bench with cache and memory models
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cache_controller;

  logic clk_100 = 1'b0;
  logic rst_n   = 1'b0;
  logic env_init = 1'b1;
  int   mem_lat  = 2;

  always #5 clk_100 = ~clk_100;

  cache_controller_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef CACHE_PERF_COUNT_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  cache_controller #(.ADDR_W(16), .DATA_W(16), .OFF_W(2)) dut (
    .clk_100    (clk_100),
    .rst_n      (rst_n),
`ifdef CACHE_PERF_COUNT_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .bus        (bus)
  );

  // cache array model: synchronous read, hit/data one cycle after address
  logic [7:0]  ctag   [64];
  logic        cvalid [64];
  logic [15:0] cdata  [256];

  always @(posedge clk_100) begin
    if (env_init) begin
      for (int i = 0; i < 64; i++) cvalid[i] <= 1'b0;
      bus.cache_hit   <= 1'b0;
      bus.cache_rdata <= 16'h0;
    end else begin
      bus.cache_rdata <= cdata[bus.cache_addr[7:0]];
      bus.cache_hit   <= cvalid[bus.cache_addr[7:2]] &&
                         (ctag[bus.cache_addr[7:2]] == bus.cache_addr[15:8]);
      if (bus.cache_we) begin
        cdata[bus.cache_addr[7:0]]  <= bus.cache_wdata;
        ctag[bus.cache_addr[7:2]]   <= bus.cache_addr[15:8];
        cvalid[bus.cache_addr[7:2]] <= 1'b1;
      end
    end
  end

  // memory model: ack after mem_lat enabled edges; read word = addr + 0x1000
  int wait_cnt = 0;
  always @(posedge clk_100) begin
    if (env_init) begin
      bus.mem_ack   <= 1'b0;
      bus.mem_rdata <= 16'h0;
      wait_cnt      <= 0;
    end else if (bus.mem_ack) begin
      bus.mem_ack <= 1'b0;
      wait_cnt    <= 0;
    end else if (bus.mem_rd_en || bus.mem_wr_en) begin
      if (wait_cnt >= mem_lat - 1) begin
        bus.mem_ack   <= 1'b1;
        bus.mem_rdata <= bus.mem_addr + 16'h1000;
        wait_cnt      <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // bus monitor: running totals, sampled mid-cycle
  int          we_cnt = 0;
  int          rd_cyc = 0;
  int          wr_cyc = 0;
  int          fill_n = 0;
  logic [15:0] fill_log [32];
  logic [15:0] wr_log_addr = 16'h0;
  logic [15:0] wr_log_data = 16'h0;
  logic        both_seen = 1'b0;

  always @(negedge clk_100) begin
    if (bus.cache_we)  we_cnt <= we_cnt + 1;
    if (bus.mem_rd_en) rd_cyc <= rd_cyc + 1;
    if (bus.mem_wr_en) wr_cyc <= wr_cyc + 1;
    if (bus.mem_rd_en && bus.mem_wr_en) both_seen <= 1'b1;
    if (bus.mem_rd_en && bus.mem_ack && fill_n < 32) begin
      fill_log[fill_n] <= bus.mem_addr;
      fill_n <= fill_n + 1;
    end
    if (bus.mem_wr_en && bus.mem_ack) begin
      wr_log_addr <= bus.mem_addr;
      wr_log_data <= bus.mem_wdata;
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          res_n;
  logic        res_ok;
  logic        res_busy_drop;
  logic [15:0] res_rd;
  int          s_we, s_rd, s_wr, s_fill;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    s_we   = we_cnt;
    s_rd   = rd_cyc;
    s_wr   = wr_cyc;
    s_fill = fill_n;
  endtask

  // issue one request and wait (bounded) for cpu_done; res_n counts mid-cycle samples
  task automatic run_req(input string tag, input logic we, input logic [15:0] addr,
                         input logic [15:0] wd, input logic hold, input logic [15:0] hold_addr);
    @(negedge clk_100);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    @(posedge clk_100);
    res_n = 0; res_ok = 1'b0; res_busy_drop = 1'b0; res_rd = 16'h0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_100);
      res_n++;
      if (i == 0) begin
        bus.cpu_req  = hold;
        bus.cpu_addr = hold_addr;
        bus.cpu_we   = 1'b0;
      end
      if (!bus.cpu_busy) res_busy_drop = 1'b1;
      if (bus.cpu_done) begin
        res_ok = 1'b1;
        res_rd = bus.cpu_rdata;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    check({tag, "_done"}, 96'(res_ok), 96'd1);
  endtask

  initial begin
    logic ok;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 16'h0;
    repeat (3) @(posedge clk_100);
    @(negedge clk_100);
    env_init = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk_100);
    check("reset_flags", {91'd0, bus.cpu_done, bus.cpu_busy, bus.cache_we, bus.mem_rd_en, bus.mem_wr_en}, 96'd0);
    check("reset_buses", {bus.cpu_rdata, bus.cache_addr, bus.cache_wdata, bus.mem_addr, bus.mem_wdata, 16'h0}, 96'd0);

    // reset in the middle of a line fill
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h3320;
    @(posedge clk_100);
    @(negedge clk_100);
    bus.cpu_req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_rd_en) begin ok = 1'b1; break; end
      @(negedge clk_100);
    end
    check("midfill_reached", 96'(ok), 96'd1);
    rst_n = 1'b0;
    @(posedge clk_100);
    @(negedge clk_100);
    check("midfill_rst_flags", {91'd0, bus.cpu_done, bus.cpu_busy, bus.cache_we, bus.mem_rd_en, bus.mem_wr_en}, 96'd0);
    check("midfill_rst_buses", {bus.cpu_rdata, bus.cache_addr, bus.cache_wdata, bus.mem_addr, bus.mem_wdata, 16'h0}, 96'd0);
`ifdef CACHE_PERF_COUNT_EN
    check("midfill_rst_counts", {64'd0, hit_count, miss_count}, 96'd0);
`endif
    rst_n = 1'b1;

    // cold read miss: fill F004..F007, re-lookup, return F005+1000
    snap();
    run_req("miss_f005", 1'b0, 16'hF005, 16'h0, 1'b0, 16'hF005);
    check("miss_f005_rdata", 96'(res_rd), 96'h0005);
    check("miss_f005_cycles", 96'(res_n), 96'd21);
    check("miss_f005_cache_we", 96'(we_cnt - s_we), 96'd4);
    check("miss_f005_rd_cycles", 96'(rd_cyc - s_rd), 96'd12);
    check("miss_f005_fill_addrs", {32'h0, fill_log[s_fill], fill_log[s_fill+1], fill_log[s_fill+2], fill_log[s_fill+3]},
          {32'h0, 16'hF004, 16'hF005, 16'hF006, 16'hF007});

    // repeat read hits in 3 cycles with no memory or cache write traffic
    snap();
    run_req("hit_f005", 1'b0, 16'hF005, 16'h0, 1'b0, 16'hF005);
    check("hit_f005_rdata", 96'(res_rd), 96'h0005);
    check("hit_f005_cycles", 96'(res_n), 96'd3);
    check("hit_f005_quiet", {32'(we_cnt - s_we), 32'(rd_cyc - s_rd), 32'(wr_cyc - s_wr)}, 96'd0);

    // write hit: one cache write plus write-through
    snap();
    run_req("whit_f006", 1'b1, 16'hF006, 16'hBEEF, 1'b0, 16'hF006);
    check("whit_f006_cycles", 96'(res_n), 96'd6);
    check("whit_f006_cache_we", 96'(we_cnt - s_we), 96'd1);
    check("whit_f006_wr_cycles", 96'(wr_cyc - s_wr), 96'd3);
    check("whit_f006_mem", {64'h0, wr_log_addr, wr_log_data}, {64'h0, 16'hF006, 16'hBEEF});

    // write miss: memory only, no allocate
    snap();
    run_req("wmiss_0a10", 1'b1, 16'h0A10, 16'h1234, 1'b0, 16'h0A10);
    check("wmiss_0a10_cache_we", 96'(we_cnt - s_we), 96'd0);
    check("wmiss_0a10_mem", {64'h0, wr_log_addr, wr_log_data}, {64'h0, 16'h0A10, 16'h1234});
    check("wmiss_0a10_rd_cycles", 96'(rd_cyc - s_rd), 96'd0);

    // busy: second request held high during a slow fill is ignored
    mem_lat = 20;
    snap();
    run_req("busy_5540", 1'b0, 16'h5540, 16'h0, 1'b1, 16'h7780);
    check("busy_5540_rdata", 96'(res_rd), 96'h6540);
    check("busy_5540_stay_busy", 96'(res_busy_drop), 96'd0);
    check("busy_5540_fill_addrs", {64'h0, fill_log[s_fill], fill_log[s_fill+3]}, {64'h0, 16'h5540, 16'h5543});
    @(negedge clk_100);
    @(negedge clk_100);
    check("busy_idle_after", 96'(bus.cpu_busy), 96'd0);
    mem_lat = 2;
`ifdef CACHE_PERF_COUNT_EN
    check("perf_counts_a", {64'd0, hit_count, miss_count}, {64'd0, 16'd2, 16'd3});
`endif

    // follow-up reads: F006 hits with the written data, 0A10 misses and fills
    snap();
    run_req("rd_f006", 1'b0, 16'hF006, 16'h0, 1'b0, 16'hF006);
    check("rd_f006_rdata", 96'(res_rd), 96'hBEEF);
    check("rd_f006_cycles", 96'(res_n), 96'd3);
    snap();
    run_req("rd_0a10", 1'b0, 16'h0A10, 16'h0, 1'b0, 16'h0A10);
    check("rd_0a10_rdata", 96'(res_rd), 96'h1A10);
    check("rd_0a10_cache_we", 96'(we_cnt - s_we), 96'd4);
    check("rd_0a10_cycles", 96'(res_n), 96'd21);
`ifdef CACHE_PERF_COUNT_EN
    check("perf_counts_b", {64'd0, hit_count, miss_count}, {64'd0, 16'd3, 16'd4});
`endif
    check("rd_wr_exclusive", 96'(both_seen), 96'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequences the direct-mapped 16-bit cache (8-bit tag, 6-bit index, 2-bit word offset) between the CPU memory stage and main memory.
- Handles read lookup and line fill on a read miss (4 words).
- Writes are write-through with no allocate on a miss.
- Owns every cache control strobe; the cache itself holds the tag, valid and data arrays.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data word width.
- OFF_W, 2, word-offset bits; line size is 2**OFF_W words.

Ports:
- clk_100  in  1  system clock, 100 MHz; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read; latched with cpu_req.
- cpu_addr  in  ADDR_W  request address; latched with cpu_req.
- cpu_wdata  in  DATA_W  write data; latched with cpu_req.
- cpu_rdata  out  DATA_W  read data; valid while cpu_done = 1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high whenever state is not IDLE.
- cache_addr  out  ADDR_W  address to cache.
- cache_wdata  out  DATA_W  data to cache.
- cache_we  out  1  cache word+tag+valid write strobe.
- cache_rdata  in  DATA_W  cache read data; valid 1 cycle after cache_addr is presented.
- cache_hit  in  1  hit flag; same timing as cache_rdata.
- mem_addr  out  ADDR_W  main memory address.
- mem_wdata  out  DATA_W  main memory write data.
- mem_rd_en  out  1  memory read request; held until mem_ack.
- mem_wr_en  out  1  memory write request; held until mem_ack.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.

Behaviour:
- Reset:
  - rst_n = 0 at a clock edge forces state IDLE.
  - All outputs go to 0 and the latched request and the fill counter clear.
  - This applies mid-fill and mid-write too; partially filled lines are left as written.
- States: IDLE, LOOKUP, CHECK, FILL, FILL_WR, WRITE_MEM, RESP.
- IDLE:
  - If cpu_req = 1, latch cpu_we, cpu_addr and cpu_wdata, then go to LOOKUP.
  - cpu_req in any other state is ignored; there is no queueing.
- LOOKUP:
  - Drive cache_addr from the latched address; go to CHECK.
- CHECK, which samples cache_hit and cache_rdata:
  - Read hit: register cache_rdata into cpu_rdata; go to RESP.
  - Read miss: clear the fill counter; go to FILL.
  - Write, hit: pulse cache_we for 1 cycle with cache_wdata = latched data; go to WRITE_MEM.
  - Write, miss: go to WRITE_MEM with no cache write (no allocate).
- FILL:
  - mem_addr = {latched tag, latched index, counter}; hold mem_rd_en = 1.
  - On mem_ack: capture mem_rdata; go to FILL_WR.
- FILL_WR:
  - Pulse cache_we with cache_addr = the same address and cache_wdata = the captured word.
  - If counter = 2**OFF_W - 1, go to LOOKUP (re-lookup, which must hit).
  - Otherwise increment the counter and return to FILL.
  - The fill always runs from offset 0 to the last offset, independent of the requested offset.
- WRITE_MEM:
  - Hold mem_wr_en = 1 with mem_addr = latched address and mem_wdata = latched data.
  - On mem_ack, go to RESP.
- RESP:
  - Pulse cpu_done for 1 cycle; go to IDLE.
  - cpu_rdata holds its value until the next read completes.
- Latency, from the cpu_req sample edge to cpu_done:
  - Read hit: 3 cycles.
  - Write: 4 cycles plus memory wait.
  - Read miss: 4 × (memory latency + 1) cycles plus the lookup overhead.
- Minimum request spacing is 4 cycles (back to IDLE after RESP).
- Never assert mem_rd_en and mem_wr_en together.
- If mem_ack never arrives, wait indefinitely; there is no timeout.
- mem_ack arriving outside FILL or WRITE_MEM is ignored.
- Address fields:
  - Tag = addr[15:8].
  - Index = addr[7:2].
  - Offset = addr[1:0].
  - Counter width = OFF_W; the increment never wraps because the exit happens at the max value.

Optional Feature:
- CACHE_PERF_COUNT_EN defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - Each count increments by 1 in CHECK on a hit or a miss respectively, reads and writes alike.
  - The re-lookup after a fill is not counted.
  - Each count saturates at 16'hFFFF and clears on reset.
- CACHE_PERF_COUNT_EN undefined:
  - The ports and logic are absent.

Test Plan:
- Reset mid-fill:
  - Stimulus: rst_n = 0 for 1 cycle during FILL.
  - Required response: next cycle state is IDLE, every output is 0, and a new request is accepted normally.
- Read miss then hit:
  - Stimulus: read cpu_addr = 16'hF005 into a cold cache; memory returns word = addr + 16'h1000, ack 2 cycles after each request.
  - Required response: mem_addr steps F004, F005, F006, F007; 4 cache_we pulses; then re-lookup hits; cpu_done with cpu_rdata = 16'h0005.
- Repeat read hit:
  - Stimulus: repeat the read of 16'hF005.
  - Required response: cpu_done exactly 3 cycles after the sample edge, with cpu_rdata = 16'h0005, mem_rd_en never asserted, and cache_we never asserted.
- Write hit:
  - Stimulus: write 16'hBEEF to 16'hF006.
  - Required response: 1 cache_we pulse; mem_wr_en held with mem_addr = F006 and mem_wdata = BEEF until ack; cpu_done follows.
  - Check: a subsequent read of F006 hits and returns BEEF.
- Write miss:
  - Stimulus: write 16'h1234 to 16'h0A10 (different tag and index, line not cached).
  - Required response: no cache_we; memory write only.
  - Check: a subsequent read of 0A10 misses and fills.
- Busy handling:
  - Stimulus: cpu_req held high during a fill with a different cpu_addr; memory stalls mem_ack for 20 cycles.
  - Required response: the second request is ignored until IDLE and cpu_busy stays 1 throughout.
  - With CACHE_PERF_COUNT_EN defined, after the full sequence above: hit_count = 2, miss_count = 3.
